// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer in front of the 16-bit
// Thumb-style decoder. Owns the PC, fetches over a req/ack port, stalls
// for data-memory transactions and confines the register-file write
// enable to a single write-back cycle per instruction.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] oldpc,
  output logic        fetched,
  input  logic [15:0] dec_pc,
  input  logic        dec_ls,
  input  logic        dec_we,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        rf_we,
  input  logic        halt,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Last MEM cycle index before the transaction is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] pc_reg;
  logic [15:0] instr_reg;
  logic [7:0]  to_cnt_reg;
  logic        skip_wb_reg;
  logic        mem_err_reg;
  logic [15:0] retired_reg;
  logic        imem_req_reg;
  logic        dmem_req_reg;
  logic        fetched_reg;
  logic        halted_reg;

  // Next-state decode; acks are only honoured in their matching state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem_ack) state_next = DECODE;
      DECODE:  state_next = dec_ls ? MEM : WB;
      MEM:     if (dmem_ack || (to_cnt_reg == TIMEOUT_LAST)) state_next = WB;
      WB:      state_next = halt ? HALT : FETCH;
      HALT:    if (!halt) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, datapath registers and registered Moore strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      instr_reg    <= 16'h0000;
      to_cnt_reg   <= 8'd0;
      skip_wb_reg  <= 1'b0;
      mem_err_reg  <= 1'b0;
      retired_reg  <= 16'h0000;
      imem_req_reg <= 1'b0;
      dmem_req_reg <= 1'b0;
      fetched_reg  <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      imem_req_reg <= (state_next == FETCH);
      dmem_req_reg <= (state_next == MEM);
      fetched_reg  <= (state_next == DECODE) || (state_next == MEM) || (state_next == WB);
      halted_reg   <= (state_next == HALT);
      case (state_reg)
        FETCH: begin
          if (imem_ack) instr_reg <= imem_rdata;
        end
        DECODE: begin
          if (dec_ls) to_cnt_reg <= 8'd0;
        end
        MEM: begin
          // An ack on the final allowed cycle still counts as success.
          if (dmem_ack) begin
            skip_wb_reg <= 1'b0;
          end else if (to_cnt_reg == TIMEOUT_LAST) begin
            mem_err_reg <= 1'b1;
            skip_wb_reg <= 1'b1;
          end else begin
            to_cnt_reg <= to_cnt_reg + 8'd1;
          end
        end
        WB: begin
          pc_reg      <= dec_pc;
          retired_reg <= retired_reg + 16'd1;
          skip_wb_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The decoder's write enable only reaches the register file in WB, and
  // is suppressed after a timed-out memory access.
  assign rf_we       = (state_reg == WB) && dec_we && !skip_wb_reg;
  assign imem_req    = imem_req_reg;
  assign dmem_req    = dmem_req_reg;
  assign fetched     = fetched_reg;
  assign halted      = halted_reg;
  assign imem_addr   = pc_reg;
  assign oldpc       = pc_reg;
  assign instruction = instr_reg;
  assign mem_err     = mem_err_reg;
  assign retired     = retired_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: fetch, fetch wait states, loads,
// memory timeout, halt, PC wrap and reset in the middle of an access.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic [15:0] oldpc;
  logic        fetched;
  logic [15:0] dec_pc;
  logic        dec_ls;
  logic        dec_we;
  logic        dmem_req;
  logic        dmem_ack;
  logic        rf_we;
  logic        halt;
  logic        halted;
  logic        mem_err;
  logic [15:0] retired;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_ret = 16'h0000;

  cpu_sequencer #(.RESET_PC(16'h0000), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .oldpc(oldpc), .fetched(fetched),
    .dec_pc(dec_pc), .dec_ls(dec_ls), .dec_we(dec_we),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .rf_we(rf_we),
    .halt(halt), .halted(halted), .mem_err(mem_err), .retired(retired), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting from FETCH with an immediate fetch ack.
  // Stops on return to FETCH or on entering HALT, bounded to 60 cycles.
  task automatic run_instr(input logic [15:0] rdata, input logic ls, input logic we,
                           input logic [15:0] npc, input int ack_at, input logic hlt,
                           output int cycles, output int mem_cyc, output int pulses);
    cycles = 1; mem_cyc = 0; pulses = 0;
    imem_ack = 1'b1; imem_rdata = rdata; dec_ls = ls; dec_we = we; dec_pc = npc; halt = hlt;
    cyc();
    imem_ack = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (state == 3'd1 || state == 3'd5) break;
      cycles++;
      if (state == 3'd3) begin
        mem_cyc++;
        dmem_ack = (mem_cyc == ack_at);
      end else begin
        dmem_ack = 1'b0;
      end
      #1;
      if (rf_we) pulses++;
      cyc();
    end
    dmem_ack = 1'b0;
    exp_ret = exp_ret + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 0; imem_rdata = 0; dec_pc = 0; dec_ls = 0; dec_we = 0; dmem_ack = 0; halt = 0;
    #2;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_cmp++; if ({imem_req, dmem_req, fetched, rf_we, halted, mem_err} !== 6'b0) begin n_err++; $display("FAIL reset_strobes got %b exp 000000", {imem_req, dmem_req, fetched, rf_we, halted, mem_err}); end
    n_cmp++; if (imem_addr !== 16'h0000 || oldpc !== 16'h0000 || instruction !== 16'h0000 || retired !== 16'h0000) begin n_err++; $display("FAIL reset_data got addr=%h oldpc=%h instr=%h ret=%h exp 0", imem_addr, oldpc, instruction, retired); end
    cyc(); cyc();
    rst = 1'b0;
    n_cmp++; if (state !== 3'd0 || imem_req !== 1'b0) begin n_err++; $display("FAIL idle_cycle got state=%0d req=%b exp 0/0", state, imem_req); end
    cyc();
    n_cmp++; if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL first_fetch got state=%0d req=%b addr=%h exp 1/1/0000", state, imem_req, imem_addr); end
  endtask

  task automatic test_first_instr();
    int c, m, p;
    run_instr(16'h2005, 1'b0, 1'b1, 16'h0001, 0, 1'b0, c, m, p);
    n_cmp++; if (c !== 3) begin n_err++; $display("FAIL movs_latency got %0d exp 3", c); end
    n_cmp++; if (p !== 1) begin n_err++; $display("FAIL movs_rf_we got %0d pulses exp 1", p); end
    n_cmp++; if (instruction !== 16'h2005) begin n_err++; $display("FAIL movs_instr got %h exp 2005", instruction); end
    n_cmp++; if (state !== 3'd1 || imem_addr !== 16'h0001 || retired !== exp_ret) begin n_err++; $display("FAIL movs_next got state=%0d addr=%h ret=%h exp 1/0001/%h", state, imem_addr, retired, exp_ret); end
  endtask

  task automatic test_fetch_wait();
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req !== 1'b1 || imem_addr !== 16'h0001 || fetched !== 1'b0 || state !== 3'd1) bad++;
      if (i < 4) cyc();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL fetch_wait got %0d bad cycles exp 0", bad); end
    imem_ack = 1'b1; imem_rdata = 16'h1234; dec_ls = 0; dec_we = 1; dec_pc = 16'h0002;
    cyc();
    imem_ack = 1'b0;
    n_cmp++; if (state !== 3'd2 || fetched !== 1'b1 || imem_req !== 1'b0 || instruction !== 16'h1234) begin n_err++; $display("FAIL fetch_decode got state=%0d fet=%b req=%b instr=%h exp 2/1/0/1234", state, fetched, imem_req, instruction); end
    cyc(); cyc();
    exp_ret = exp_ret + 16'd1;
    n_cmp++; if (state !== 3'd1 || imem_addr !== 16'h0002 || retired !== exp_ret) begin n_err++; $display("FAIL fetch_next got state=%0d addr=%h ret=%h exp 1/0002/%h", state, imem_addr, retired, exp_ret); end
  endtask

  task automatic test_load();
    int c, m, p;
    run_instr(16'h6800, 1'b1, 1'b1, 16'h0003, 3, 1'b0, c, m, p);
    n_cmp++; if (c !== 6 || m !== 3) begin n_err++; $display("FAIL load_latency got %0d/%0d exp 6/3", c, m); end
    n_cmp++; if (p !== 1 || mem_err !== 1'b0) begin n_err++; $display("FAIL load_wb got pulses=%0d err=%b exp 1/0", p, mem_err); end
    // Ack arriving on the very last allowed MEM cycle is still a success.
    run_instr(16'h6801, 1'b1, 1'b1, 16'h0004, 8, 1'b0, c, m, p);
    n_cmp++; if (m !== 8 || p !== 1 || mem_err !== 1'b0) begin n_err++; $display("FAIL load_edge_ack got mem=%0d pulses=%0d err=%b exp 8/1/0", m, p, mem_err); end
  endtask

  task automatic test_timeout();
    int c, m, p;
    run_instr(16'h6802, 1'b1, 1'b1, 16'h0010, 0, 1'b0, c, m, p);
    n_cmp++; if (m !== 8 || c !== 11) begin n_err++; $display("FAIL timeout_cycles got mem=%0d total=%0d exp 8/11", m, c); end
    n_cmp++; if (p !== 0 || mem_err !== 1'b1) begin n_err++; $display("FAIL timeout_wb got pulses=%0d err=%b exp 0/1", p, mem_err); end
    n_cmp++; if (imem_addr !== 16'h0010 || retired !== exp_ret) begin n_err++; $display("FAIL timeout_pc got addr=%h ret=%h exp 0010/%h", imem_addr, retired, exp_ret); end
    run_instr(16'h2101, 1'b0, 1'b1, 16'h0011, 0, 1'b0, c, m, p);
    n_cmp++; if (mem_err !== 1'b1 || p !== 1) begin n_err++; $display("FAIL timeout_sticky got err=%b pulses=%0d exp 1/1", mem_err, p); end
  endtask

  task automatic test_halt();
    int c, m, p;
    int bad = 0;
    run_instr(16'hBF00, 1'b0, 1'b0, 16'h0040, 0, 1'b1, c, m, p);
    n_cmp++; if (state !== 3'd5 || halted !== 1'b1 || imem_req !== 1'b0 || c !== 3) begin n_err++; $display("FAIL halt_enter got state=%0d halted=%b req=%b cyc=%0d exp 5/1/0/3", state, halted, imem_req, c); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (state !== 3'd5 || halted !== 1'b1 || imem_req !== 1'b0 || fetched !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL halt_hold got %0d bad cycles exp 0", bad); end
    halt = 1'b0;
    cyc();
    n_cmp++; if (state !== 3'd1 || halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_err++; $display("FAIL halt_release got state=%0d halted=%b req=%b addr=%h exp 1/0/1/0040", state, halted, imem_req, imem_addr); end
  endtask

  task automatic test_pc_wrap();
    int c, m, p;
    run_instr(16'hE7FF, 1'b0, 1'b0, 16'hFFFF, 0, 1'b0, c, m, p);
    n_cmp++; if (oldpc !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pre got oldpc=%h exp ffff", oldpc); end
    run_instr(16'hE000, 1'b0, 1'b0, 16'h0000, 0, 1'b0, c, m, p);
    n_cmp++; if (imem_addr !== 16'h0000 || oldpc !== 16'h0000 || retired !== exp_ret) begin n_err++; $display("FAIL wrap_pc got addr=%h oldpc=%h ret=%h exp 0000/0000/%h", imem_addr, oldpc, retired, exp_ret); end
  endtask

  task automatic test_reset_in_mem();
    imem_ack = 1'b1; imem_rdata = 16'h6803; dec_ls = 1; dec_we = 1; dec_pc = 16'h0077;
    cyc();
    imem_ack = 1'b0;
    cyc();
    n_cmp++; if (state !== 3'd3 || dmem_req !== 1'b1) begin n_err++; $display("FAIL rst_pre got state=%0d dreq=%b exp 3/1", state, dmem_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if (state !== 3'd0 || {imem_req, dmem_req, fetched, rf_we, halted, mem_err} !== 6'b0) begin n_err++; $display("FAIL rst_mem_strobes got state=%0d strobes=%b exp 0/000000", state, {imem_req, dmem_req, fetched, rf_we, halted, mem_err}); end
    n_cmp++; if (imem_addr !== 16'h0000 || instruction !== 16'h0000 || retired !== 16'h0000) begin n_err++; $display("FAIL rst_mem_data got addr=%h instr=%h ret=%h exp 0", imem_addr, instruction, retired); end
    cyc();
    rst = 1'b0; dec_ls = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_first_instr();
    test_fetch_wait();
    test_load();
    test_timeout();
    test_halt();
    test_pc_wrap();
    test_reset_in_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
